// File: rtl/pipe_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_reg : valid/ready pipeline register, skid or single entry  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module pipe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 16,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_data0;
  logic [DATA_W-1:0]   r_data1;
  logic [CTRL_W-1:0]   r_ctrl0;
  logic [CTRL_W-1:0]   r_ctrl1;
  logic [DATA_W-1:0]   w_data0_nxt;
  logic [DATA_W-1:0]   w_data1_nxt;
  logic [CTRL_W-1:0]   w_ctrl0_nxt;
  logic [CTRL_W-1:0]   w_ctrl1_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_stall;

  assign out_valid  = (r_state != ST_EMPTY);
  assign out_data   = r_data0;
  assign out_ctrl   = out_valid ? r_ctrl0 : {CTRL_W{1'b0}};
  assign stall_cnt  = r_stall_cnt;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;
  assign w_stall    = out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Slot 0 is always the head; slot 1 only fills while the head is stalled.
  always_comb begin
    w_state_nxt = r_state;
    w_data0_nxt = r_data0;
    w_data1_nxt = r_data1;
    w_ctrl0_nxt = r_ctrl0;
    w_ctrl1_nxt = r_ctrl1;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_data0_nxt = {DATA_W{1'b0}};
      w_data1_nxt = {DATA_W{1'b0}};
      w_ctrl0_nxt = {CTRL_W{1'b0}};
      w_ctrl1_nxt = {CTRL_W{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_data0_nxt = in_data;
            w_ctrl0_nxt = in_ctrl;
          end
        end
        ST_ONE: begin
          case ({w_in_xfer, w_out_xfer})
            2'b10: begin
              w_state_nxt = ST_TWO;
              w_data1_nxt = in_data;
              w_ctrl1_nxt = in_ctrl;
            end
            2'b01: w_state_nxt = ST_EMPTY;
            2'b11: begin
              w_data0_nxt = in_data;
              w_ctrl0_nxt = in_ctrl;
            end
            default: w_state_nxt = ST_ONE;
          endcase
        end
        ST_TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_data0_nxt = r_data1;
            w_ctrl0_nxt = r_ctrl1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= {DATA_W{1'b0}};
      r_data1 <= {DATA_W{1'b0}};
      r_ctrl0 <= {CTRL_W{1'b0}};
      r_ctrl1 <= {CTRL_W{1'b0}};
    end else begin
      r_data0 <= w_data0_nxt;
      r_data1 <= w_data1_nxt;
      r_ctrl0 <= w_ctrl0_nxt;
      r_ctrl1 <= w_ctrl1_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != c_cnt_max)) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic r_in_ready;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_in_ready <= 1'b0;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
        end
      end
      assign in_ready = r_in_ready;
    end else begin : g_single
      // Keeps in_ready low while in reset and until the first edge after it.
      logic r_alive;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_alive <= 1'b0;
        end else begin
          r_alive <= 1'b1;
        end
      end
      assign in_ready = r_alive & (~out_valid | out_ready);
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the payload data field.
REQ-002 The block SHALL have parameter CTRL_W, default 16, giving the width of the control field; all control bits are active-high enables.
REQ-003 The block SHALL have parameter SKID_EN, default 1; 1 selects a two-entry skid stage and 0 selects a single-entry stage.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous kill of all held entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the stage accepts an entry this cycle.
REQ-010 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-011 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control.
REQ-012 The block SHALL have port out_valid, output, 1 bit: downstream entry present.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts an entry.
REQ-014 The block SHALL have port out_data, output, DATA_W bits: payload of the head entry.
REQ-015 The block SHALL have port out_ctrl, output, CTRL_W bits: control of the head entry, masked when invalid.
REQ-016 The block SHALL have port stall_cnt, output, CNT_W bits: saturating count of back-pressured cycles.

Function
REQ-017 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-018 With SKID_EN=1, the block SHALL hold state EMPTY, ONE or TWO, and in_ready SHALL be a registered signal equal to 1 exactly when the state is not TWO.
REQ-019 With SKID_EN=1, the transitions SHALL be: EMPTY+in goes to ONE; ONE+in without out goes to TWO; ONE+out without in goes to EMPTY; ONE+in+out stays ONE; TWO+out goes to ONE; all other cases hold.
REQ-020 With SKID_EN=0, the block SHALL hold at most one entry, and in_ready SHALL be the combinational term (!out_valid || out_ready).
REQ-021 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL appear on out_* after edge N when the stage was empty or draining.
REQ-022 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush or reset.
REQ-023 out_valid SHALL equal (state != EMPTY), and out_data/out_ctrl SHALL present the oldest held entry.
REQ-024 out_ctrl SHALL be driven to all zeros whenever out_valid=0 (bubble), so that no enable reaches the downstream stage.
REQ-025 out_data SHALL hold its last value while no output transfer occurs and SHALL be 0 after reset or flush.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL remain stable.
REQ-027 On flush=1 at an edge, all entries SHALL be discarded, including any entry offered in that cycle; the state SHALL become EMPTY, stored data/ctrl SHALL become 0, and in_ready SHALL be 1 in the next cycle.
REQ-028 flush SHALL take priority over simultaneous input and output transfers, and no output transfer SHALL be credited in the flush cycle.
REQ-029 stall_cnt SHALL increment by 1 on each edge where out_valid=1 and out_ready=0, SHALL saturate at 2^CNT_W-1 without wrapping, and SHALL not be cleared by flush.
REQ-030 in_data and in_ctrl SHALL be ignored when no input transfer occurs.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force state EMPTY, out_valid=0, out_data=0, out_ctrl=0 and stall_cnt=0, and in_ready SHALL be 0.
REQ-032 In the first edge after rst_n rises, in_ready SHALL become 1 (for SKID_EN=1).
REQ-033 A reset asserted mid-transfer SHALL discard all entries, and no partial entry SHALL appear on exit from reset.

Verification
REQ-034 The bench SHALL cover streaming: with out_ready=1 and SKID_EN=1, offer data 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 one cycle later each, in_ready always 1, stall_cnt=0.
REQ-035 The bench SHALL cover back-pressure: with out_ready=0, offer 0xA0 then 0xA1 -> state TWO, in_ready=0, stall_cnt increments each cycle; on release out_ready=1 -> 0xA0 then 0xA1 with no loss.
REQ-036 The bench SHALL cover flush: with two entries held, plus in_valid=1 and data 0xFF in the flush cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, and 0xFF never appears.
REQ-037 The bench SHALL cover bubble masking: after accepting an entry with in_ctrl=0xFFFF, hold in_valid=0 and out_ready=1 -> the cycle after the transfer gives out_valid=0 and out_ctrl=0x0000.
REQ-038 The bench SHALL cover saturation: with CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-039 The bench SHALL cover async reset: drop rst_n mid-cycle while TWO entries are held -> outputs clear immediately without a clock edge; after release, a new entry 0x5 passes through cleanly.
